// File: rtl/branch_predictor_param.sv
// -----------------------------------------------------------------------------
// branch_predictor_param
//
// Dynamic branch predictor for Fetch: a direct-mapped, tagged BTB alongside a
// table of 2-bit saturating direction counters (BHT). The index can be
// optionally hashed with the global history (gshare). Lookup is purely
// combinational. Decode writes back resolved branches, and the block keeps
// saturating performance counters.
//
// Ports
//   clk          clock
//   rst          synchronous, active-low reset
//   lookup_pc    PC fetched this cycle
//   pred_taken   predicted taken (BTB hit and counter MSB set)
//   pred_hit     BTB entry valid and tag matches
//   pred_state   BHT counter at the lookup index
//   pred_target  BTB target when predicted taken, else lookup_pc+2
//   upd_valid    resolved branch from Decode this cycle
//   upd_pc       PC of the resolved branch
//   upd_taken    resolved direction
//   upd_target   resolved target
//   upd_mispred  Decode flagged a misprediction
//   flush        invalidate all BTB entries and clear history
//   ghr          global history register (LSB = newest outcome)
//   cnt_branches resolved branch count (saturating)
//   cnt_mispred  misprediction count (saturating)
// -----------------------------------------------------------------------------
module branch_predictor_param #(
    parameter int PC_W   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 8,
    parameter int GSHARE = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic             pred_hit,
    output logic [1:0]       pred_state,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_mispred,
    input  logic             flush,
    output logic [IDX_W-1:0] ghr,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int DEPTH = 1 << IDX_W;

    // Table state
    logic [DEPTH-1:0]            btb_valid_q, btb_valid_d;
    logic [DEPTH-1:0][TAG_W-1:0] btb_tag_q,   btb_tag_d;
    logic [DEPTH-1:0][PC_W-1:0]  btb_tgt_q,   btb_tgt_d;
    logic [DEPTH-1:0][1:0]       bht_q,       bht_d;
    logic [IDX_W-1:0]            ghr_q,       ghr_d;
    logic [CNT_W-1:0]            cnt_br_q,    cnt_br_d;
    logic [CNT_W-1:0]            cnt_mp_q,    cnt_mp_d;

    // History contribution to the index; zero in plain PC-indexed mode.
    logic [IDX_W-1:0] hist_mix;
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             btb_wr;

    assign hist_mix = (GSHARE != 0) ? ghr_q : '0;
    assign lk_idx   = lookup_pc[IDX_W:1] ^ hist_mix;
    assign upd_idx  = upd_pc[IDX_W:1] ^ hist_mix;
    // The tag is always raw PC bits so gshare aliasing is still detected.
    assign lk_tag   = lookup_pc[IDX_W+TAG_W:IDX_W+1];
    assign upd_tag  = upd_pc[IDX_W+TAG_W:IDX_W+1];

    // Only the high/low PC bits outside index+tag go unused here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc, upd_pc};

    // ---------------- Lookup (combinational, no bypass) ----------------
    assign pred_hit    = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign pred_state  = bht_q[lk_idx];
    assign pred_taken  = pred_hit & pred_state[1];
    assign pred_target = pred_taken ? btb_tgt_q[lk_idx] : lookup_pc + PC_W'(2);

    assign ghr          = ghr_q;
    assign cnt_branches = cnt_br_q;
    assign cnt_mispred  = cnt_mp_q;

    // A flush in the same cycle drops the BTB allocation; reset ignores it.
    assign btb_wr = rst & upd_valid & upd_taken & ~flush;

    // ---------------- Per-entry next state ----------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic sel;
        assign sel = (upd_idx == IDX_W'(gi));

        // BHT updates even when a flush coincides with the update.
        assign bht_d[gi] = !(upd_valid && sel) ? bht_q[gi] :
                           upd_taken ? ((bht_q[gi] == 2'b11) ? 2'b11 : bht_q[gi] + 2'b01)
                                     : ((bht_q[gi] == 2'b00) ? 2'b00 : bht_q[gi] - 2'b01);

        assign btb_valid_d[gi] = flush          ? 1'b0 :
                                 (btb_wr && sel) ? 1'b1 : btb_valid_q[gi];
        assign btb_tag_d[gi]   = (btb_wr && sel) ? upd_tag    : btb_tag_q[gi];
        assign btb_tgt_d[gi]   = (btb_wr && sel) ? upd_target : btb_tgt_q[gi];
    end

    // ---------------- History and performance counters ----------------
    always_comb begin
        ghr_d    = ghr_q;
        cnt_br_d = cnt_br_q;
        cnt_mp_d = cnt_mp_q;
        if (upd_valid) begin
            ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
            if (cnt_br_q != '1) cnt_br_d = cnt_br_q + CNT_W'(1);
            if (upd_mispred && (cnt_mp_q != '1)) cnt_mp_d = cnt_mp_q + CNT_W'(1);
        end
        if (flush) ghr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_valid_q <= '0;
            bht_q       <= {DEPTH{2'b01}};
            ghr_q       <= '0;
            cnt_br_q    <= '0;
            cnt_mp_q    <= '0;
        end else begin
            btb_valid_q <= btb_valid_d;
            bht_q       <= bht_d;
            ghr_q       <= ghr_d;
            cnt_br_q    <= cnt_br_d;
            cnt_mp_q    <= cnt_mp_d;
        end
    end

    // Tag/target payload needs no reset: it is qualified by the valid bits.
    always_ff @(posedge clk) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end

endmodule
